// File: rtl/obi_rr_arbiter_pkg.sv
// rtl/obi_rr_arbiter_pkg.sv - shared types and bus widths for the OBI round-robin arbiter
package obi_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    localparam int OBI_ADDR_W = 32;
    localparam int OBI_DATA_W = 32;
    localparam int OBI_BE_W   = 4;

endpackage

// File: rtl/obi_rr_arbiter_if.sv
// rtl/obi_rr_arbiter_if.sv - requester-side and shared-slave OBI signals of the arbiter
interface obi_rr_arbiter_if
    import obi_arb_pkg::*;
#(
    parameter int MASTERS = 3
) ();

    logic [MASTERS-1:0]                 master_req_i;
    logic [MASTERS-1:0]                 master_gnt_o;
    logic [MASTERS-1:0]                 master_rvalid_o;
    logic [MASTERS-1:0]                 master_we_i;
    logic [MASTERS-1:0][OBI_BE_W-1:0]   master_be_i;
    logic [MASTERS-1:0][OBI_ADDR_W-1:0] master_addr_i;
    logic [MASTERS-1:0][OBI_DATA_W-1:0] master_wdata_i;
    logic [MASTERS-1:0][OBI_DATA_W-1:0] master_rdata_o;

    logic                  slave_req_o;
    logic                  slave_gnt_i;
    logic                  slave_rvalid_i;
    logic                  slave_we_o;
    logic [OBI_BE_W-1:0]   slave_be_o;
    logic [OBI_ADDR_W-1:0] slave_addr_o;
    logic [OBI_DATA_W-1:0] slave_wdata_o;
    logic [OBI_DATA_W-1:0] slave_rdata_i;

    logic                  resp_err_o;

    // Arbiter view: it serves the requesters and drives the shared slave port.
    modport slave (
        input  master_req_i, master_we_i, master_be_i, master_addr_i, master_wdata_i,
        input  slave_gnt_i, slave_rvalid_i, slave_rdata_i,
        output master_gnt_o, master_rvalid_o, master_rdata_o,
        output slave_req_o, slave_we_o, slave_be_o, slave_addr_o, slave_wdata_o,
        output resp_err_o
    );

    // Environment view: the requesters plus the memory behind the shared port.
    modport master (
        output master_req_i, master_we_i, master_be_i, master_addr_i, master_wdata_i,
        output slave_gnt_i, slave_rvalid_i, slave_rdata_i,
        input  master_gnt_o, master_rvalid_o, master_rdata_o,
        input  slave_req_o, slave_we_o, slave_be_o, slave_addr_o, slave_wdata_o,
        input  resp_err_o
    );

endinterface

// File: rtl/obi_rr_arbiter_id_fifo.sv
// rtl/obi_rr_arbiter_id_fifo.sv - small sync FIFO holding master IDs of outstanding requests
module obi_arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign rdata     = r_mem[r_rd_ptr];

    // Storage is written only on an accepted push; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; explicit wrap keeps DEPTH=1 well defined.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/obi_rr_arbiter.sv
// rtl/obi_rr_arbiter.sv - OBI round-robin arbiter with ID-FIFO response routing; option OBI_RR_ARB_BURST_LOCK_EN
module obi_rr_arbiter
    import obi_arb_pkg::*;
#(
    parameter int MASTERS         = 3,
    parameter int MAX_OUTSTANDING = 2,
    parameter int MAX_BURST       = 4,
    parameter int ID_BITS         = $clog2(MASTERS)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    obi_rr_arbiter_if.slave bus
);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [ID_BITS-1:0] r_rr_ptr;
    logic [ID_BITS-1:0] r_sel;
    logic [ID_BITS-1:0] w_sel;
    logic [ID_BITS-1:0] w_scan_sel;
    logic [ID_BITS-1:0] w_base;
    logic [ID_BITS-1:0] w_head;
    logic             w_any;
    logic             w_req;
    logic             w_accept;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_found;
    int               w_idx;
    logic             r_err;

    function automatic logic [ID_BITS-1:0] inc_wrap(input logic [ID_BITS-1:0] v);
        return (v == ID_BITS'(MASTERS - 1)) ? '0 : v + 1'b1;
    endfunction

`ifdef OBI_RR_ARB_BURST_LOCK_EN
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    logic [BURST_W-1:0] r_burst_cnt;
    logic [BURST_W-1:0] w_cnt_nxt;
    logic [ID_BITS-1:0] r_last;
    logic               w_in_burst;
    logic               w_lock;
    logic               w_same;

    // While a burst is open the pointer is stale; the scan restarts after the bursting master.
    assign w_in_burst = (r_burst_cnt != '0);
    assign w_base     = w_in_burst ? inc_wrap(r_last) : r_rr_ptr;
    assign w_lock     = w_in_burst & bus.master_req_i[r_last];
    assign w_same     = w_in_burst & (w_sel == r_last);
    assign w_cnt_nxt  = w_same ? r_burst_cnt + 1'b1 : BURST_W'(1);

    // Burst bookkeeping; the pointer moves only when a burst closes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_burst_cnt <= '0;
            r_last      <= '0;
            r_rr_ptr    <= '0;
        end else if (w_accept) begin
            r_last <= w_sel;
            if (w_cnt_nxt == BURST_W'(MAX_BURST)) begin
                r_burst_cnt <= '0;
                r_rr_ptr    <= inc_wrap(w_sel);
            end else begin
                r_burst_cnt <= w_cnt_nxt;
            end
        end else if (r_state == ARB_IDLE && w_in_burst && !bus.master_req_i[r_last]) begin
            r_burst_cnt <= '0;
            r_rr_ptr    <= inc_wrap(r_last);
        end
    end
`else
    logic w_unused_burst;

    assign w_unused_burst = (MAX_BURST > 0);
    assign w_base         = r_rr_ptr;

    // Pure round-robin: the pointer moves past every accepted master.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= inc_wrap(w_sel);
        end
    end
`endif

    assign w_any    = |bus.master_req_i;
    assign w_accept = w_req & bus.slave_gnt_i;
    assign w_pop    = bus.slave_rvalid_i & ~w_empty;

    // First requester at or after the scan base, wrapping past MASTERS-1.
    always_comb begin
        w_scan_sel = w_base;
        w_found    = 1'b0;
        w_idx      = 0;
        for (int i = 0; i < MASTERS; i++) begin
            w_idx = int'(w_base) + i;
            if (w_idx >= MASTERS) begin
                w_idx = w_idx - MASTERS;
            end
            if (!w_found && bus.master_req_i[w_idx]) begin
                w_scan_sel = ID_BITS'(w_idx);
                w_found    = 1'b1;
            end
        end
    end

    // Arbitration FSM: pick in IDLE, freeze the choice in HOLD until the slave grants.
    always_comb begin
        w_state_nxt = r_state;
        w_sel       = w_scan_sel;
        w_req       = 1'b0;
        case (r_state)
            ARB_IDLE: begin
`ifdef OBI_RR_ARB_BURST_LOCK_EN
                if (w_lock) begin
                    w_sel = r_last;
                end
`endif
                w_req = w_any & ~w_full;
                if (w_req && !bus.slave_gnt_i) begin
                    w_state_nxt = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                w_sel = r_sel;
                w_req = 1'b1;
                if (bus.slave_gnt_i) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // State register, held selection and the sticky stray-response flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ARB_IDLE;
            r_sel   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ARB_IDLE) begin
                r_sel <= w_sel;
            end
            if (bus.slave_rvalid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    obi_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_BITS)
    ) u_id_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (w_accept),
        .pop   (w_pop),
        .wdata (w_sel),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Grant and response steering: one-hot on the selected / head master.
    always_comb begin
        bus.master_gnt_o    = '0;
        bus.master_rvalid_o = '0;
        if (w_accept) begin
            bus.master_gnt_o[w_sel] = 1'b1;
        end
        if (w_pop) begin
            bus.master_rvalid_o[w_head] = 1'b1;
        end
    end

    assign bus.master_rdata_o = {MASTERS{bus.slave_rdata_i}};
    assign bus.slave_req_o    = w_req;
    assign bus.slave_we_o     = bus.master_we_i[w_sel];
    assign bus.slave_be_o     = bus.master_be_i[w_sel];
    assign bus.slave_addr_o   = bus.master_addr_i[w_sel];
    assign bus.slave_wdata_o  = bus.master_wdata_i[w_sel];
    assign bus.resp_err_o     = r_err;

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// tb/tb_obi_rr_arbiter.sv - directed self-checking bench for obi_rr_arbiter
module tb_obi_rr_arbiter;

    localparam int MASTERS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [31:0] addr_tab [3];
    logic [31:0] wdata_tab [3];
    logic [3:0]  be_tab [3];
    logic        we_tab [3];
    int          exp_g [9];

    obi_rr_arbiter_if #(.MASTERS(MASTERS)) bus ();

    obi_rr_arbiter #(
        .MASTERS         (MASTERS),
        .MAX_OUTSTANDING (2),
        .MAX_BURST       (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle's inputs just after the edge, then settle to mid-cycle.
    task automatic set_in(input logic [2:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
        bus.master_req_i   = req;
        bus.slave_gnt_i    = gnt;
        bus.slave_rvalid_i = rv;
        bus.slave_rdata_i  = rd;
        #4;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        addr_tab  = '{32'h0000_1000, 32'h0000_0100, 32'h0000_3000};
        wdata_tab = '{32'h0000_00D0, 32'h0000_00D1, 32'h0000_00D2};
        be_tab    = '{4'hF, 4'h1, 4'h3};
        we_tab    = '{1'b0, 1'b1, 1'b0};
`ifdef OBI_RR_ARB_BURST_LOCK_EN
        exp_g = '{0, 0, 0, 0, 2, 2, 2, 2, 0};
`else
        exp_g = '{0, 2, 0, 2, 0, 2, 0, 2, 0};
`endif
        for (int m = 0; m < MASTERS; m++) begin
            bus.master_addr_i[m]  = addr_tab[m];
            bus.master_wdata_i[m] = wdata_tab[m];
            bus.master_be_i[m]    = be_tab[m];
            bus.master_we_i[m]    = we_tab[m];
        end
        bus.master_req_i   = '0;
        bus.slave_gnt_i    = 1'b0;
        bus.slave_rvalid_i = 1'b0;
        bus.slave_rdata_i  = '0;

        // Reset state
        #2;
        check("rst_gnt", bus.master_gnt_o, 0);
        check("rst_rvalid", bus.master_rvalid_o, 0);
        check("rst_req", bus.slave_req_o, 0);
        check("rst_err", bus.resp_err_o, 0);
        tick;
        rst = 1'b0;

        // All three request, slave grants every cycle, rvalid one cycle later
        for (int k = 0; k < 6; k++) begin
            set_in(3'b111, 1'b1, k > 0, 32'hA0 + k - 1);
            check("rr_gnt", bus.master_gnt_o, 1 << (k % 3));
            check("rr_addr", bus.slave_addr_o, addr_tab[k % 3]);
            check("rr_wdata", bus.slave_wdata_o, wdata_tab[k % 3]);
            check("rr_be", bus.slave_be_o, be_tab[k % 3]);
            check("rr_we", bus.slave_we_o, we_tab[k % 3]);
            if (k > 0) begin
                check("rr_rvalid", bus.master_rvalid_o, 1 << ((k - 1) % 3));
                check("rr_rdata", bus.master_rdata_o[(k - 1) % 3], 32'hA0 + k - 1);
            end
            tick;
        end
        set_in(3'b000, 1'b1, 1'b1, 32'hA5);
        check("rr_idle_gnt", bus.master_gnt_o, 0);
        check("rr_last_rvalid", bus.master_rvalid_o, 3'b100);
        check("rr_last_rdata", bus.master_rdata_o[2], 32'hA5);
        tick;
        set_in(3'b000, 1'b0, 1'b0, 32'h0);
        check("rr_no_err", bus.resp_err_o, 0);
        tick;

        // Hold: master 1 waits for grant, master 0 arrives mid-wait
        set_in(3'b010, 1'b0, 1'b0, 32'h0);
        check("hold_req", bus.slave_req_o, 1);
        check("hold_addr0", bus.slave_addr_o, 32'h100);
        check("hold_gnt0", bus.master_gnt_o, 0);
        tick;
        set_in(3'b010, 1'b0, 1'b0, 32'h0);
        check("hold_addr1", bus.slave_addr_o, 32'h100);
        tick;
        set_in(3'b011, 1'b0, 1'b0, 32'h0);
        check("hold_addr2", bus.slave_addr_o, 32'h100);
        check("hold_req2", bus.slave_req_o, 1);
        tick;
        set_in(3'b011, 1'b1, 1'b0, 32'h0);
        check("hold_gnt", bus.master_gnt_o, 3'b010);
        check("hold_addr3", bus.slave_addr_o, 32'h100);
        tick;
        set_in(3'b001, 1'b1, 1'b0, 32'h0);
        check("hold_next_gnt", bus.master_gnt_o, 3'b001);
        check("hold_next_addr", bus.slave_addr_o, 32'h1000);
        tick;
        set_in(3'b000, 1'b0, 1'b1, 32'hB1);
        check("hold_rv1", bus.master_rvalid_o, 3'b010);
        check("hold_rd1", bus.master_rdata_o[1], 32'hB1);
        tick;
        set_in(3'b000, 1'b0, 1'b1, 32'hB0);
        check("hold_rv0", bus.master_rvalid_o, 3'b001);
        tick;

        // Full FIFO blocks the third request, even in the cycle of a pop
        set_in(3'b111, 1'b1, 1'b0, 32'h0);
        check("full_gnt1", bus.master_gnt_o, 3'b010);
        tick;
        set_in(3'b101, 1'b1, 1'b0, 32'h0);
        check("full_gnt2", bus.master_gnt_o, 3'b100);
        tick;
        set_in(3'b001, 1'b1, 1'b0, 32'h0);
        check("full_req_blk", bus.slave_req_o, 0);
        check("full_gnt_blk", bus.master_gnt_o, 0);
        tick;
        set_in(3'b001, 1'b1, 1'b1, 32'hC1);
        check("full_req_pop", bus.slave_req_o, 0);
        check("full_rv1", bus.master_rvalid_o, 3'b010);
        tick;
        set_in(3'b001, 1'b1, 1'b0, 32'h0);
        check("full_req_after", bus.slave_req_o, 1);
        check("full_gnt0", bus.master_gnt_o, 3'b001);
        tick;
        set_in(3'b000, 1'b0, 1'b1, 32'hC2);
        check("full_rv2", bus.master_rvalid_o, 3'b100);
        tick;
        set_in(3'b000, 1'b0, 1'b1, 32'hC0);
        check("full_rv0", bus.master_rvalid_o, 3'b001);
        tick;

        // Stray rvalid with empty FIFO sets the sticky error
        set_in(3'b000, 1'b0, 1'b1, 32'hEE);
        check("stray_rvalid", bus.master_rvalid_o, 0);
        check("stray_err_pre", bus.resp_err_o, 0);
        tick;
        set_in(3'b000, 1'b0, 1'b0, 32'h0);
        check("stray_err", bus.resp_err_o, 1);
        tick;
        tick;
        set_in(3'b000, 1'b0, 1'b0, 32'h0);
        check("stray_err_sticky", bus.resp_err_o, 1);
        tick;

        // Reset with two outstanding drops their IDs and restarts at master 0
        set_in(3'b111, 1'b1, 1'b0, 32'h0);
        check("rst2_gnt1", bus.master_gnt_o, 3'b010);
        tick;
        set_in(3'b111, 1'b1, 1'b0, 32'h0);
        check("rst2_gnt2", bus.master_gnt_o, 3'b100);
        tick;
        set_in(3'b000, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        check("rst2_gnt", bus.master_gnt_o, 0);
        check("rst2_req", bus.slave_req_o, 0);
        check("rst2_rvalid", bus.master_rvalid_o, 0);
        check("rst2_err", bus.resp_err_o, 0);
        tick;
        rst = 1'b0;
        set_in(3'b111, 1'b1, 1'b0, 32'h0);
        check("rst2_first_gnt", bus.master_gnt_o, 3'b001);
        tick;
        set_in(3'b000, 1'b0, 1'b1, 32'hF0);
        check("rst2_rv0", bus.master_rvalid_o, 3'b001);
        tick;
        set_in(3'b000, 1'b0, 1'b1, 32'hF1);
        check("rst2_stray", bus.master_rvalid_o, 0);
        tick;
        set_in(3'b000, 1'b0, 1'b0, 32'h0);
        check("rst2_err_set", bus.resp_err_o, 1);

        // Masters 0 and 2 request continuously: burst lock or plain alternation
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            set_in(3'b101, 1'b1, k > 0, 32'h50 + k);
            check("burst_gnt", bus.master_gnt_o, 1 << exp_g[k]);
            if (k > 0) begin
                check("burst_rvalid", bus.master_rvalid_o, 1 << exp_g[k - 1]);
            end
            tick;
        end
        set_in(3'b000, 1'b0, 1'b1, 32'h0);
        check("burst_last_rv", bus.master_rvalid_o, 1 << exp_g[8]);
        check("burst_err", bus.resp_err_o, 0);
        tick;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
- Shares one OBI slave port between MASTERS requesters using round-robin arbitration.
- Replaces fixed LSB-first priority wherever starvation matters, e.g. core I/D ports plus debug/DMA into one RAM.
- Tracks outstanding requests in an ID FIFO and routes each response back to its originating master, so slaves with multi-cycle or pipelined rvalid are supported.

Parameters:
- MASTERS, 3, number of requesting masters (>=2).
- MAX_OUTSTANDING, 2, depth of the response-routing ID FIFO (power of 2, >=1).
- MAX_BURST, 4, maximum consecutive grants to one master when OBI_RR_ARB_BURST_LOCK_EN is defined.
- ID_BITS, $clog2(MASTERS), derived width of a master index.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- master_req_i  in  [MASTERS] x 1  OBI request.
- master_gnt_o  out  [MASTERS] x 1  OBI grant.
- master_rvalid_o  out  [MASTERS] x 1  response valid.
- master_we_i  in  [MASTERS] x 1  write enable.
- master_be_i  in  [MASTERS] x 4  byte enables.
- master_addr_i  in  [MASTERS] x 32  address.
- master_wdata_i  in  [MASTERS] x 32  write data.
- master_rdata_o  out  [MASTERS] x 32  read data.
- slave_req_o  out  1  request.
- slave_gnt_i  in  1  grant.
- slave_rvalid_i  in  1  response valid.
- slave_we_o  out  1  write enable.
- slave_be_o  out  4  byte enables.
- slave_addr_o  out  32  address.
- slave_wdata_o  out  32  write data.
- slave_rdata_i  in  32  read data.
- resp_err_o  out  1  sticky: rvalid received with empty ID FIFO.

Behaviour:
- Reset (rst_i=1, asynchronous):
  - rr_ptr=0, state=ARB_IDLE, FIFO empty, resp_err_o=0.
  - All gnt/rvalid outputs 0; slave_req_o=0.
  - A reset in mid-transaction drops all outstanding IDs. Later stray slave rvalids set resp_err_o.
- Accept: a request is accepted when slave_req_o & slave_gnt_i in the same cycle. master_gnt_o[sel] = slave_req_o & slave_gnt_i; all other grants are 0.
- State machine:
  - ARB_IDLE:
    - sel = first requesting master scanning rr_ptr, rr_ptr+1, ... with wrap at MASTERS-1 -> 0.
    - slave_req_o = (any master_req_i) & ~fifo_full.
    - If presented and not granted, latch sel and go to ARB_HOLD.
  - ARB_HOLD:
    - sel frozen, slave_req_o = 1. OBI requires the master to hold its request until gnt.
    - Go to ARB_IDLE on accept.
- Datapath: slave_we/be/addr/wdata_o = fields of master sel, combinational. Zero latency from master request to slave request.
- On accept:
  - Push sel into the ID FIFO.
  - rr_ptr <= sel+1, wrapping to 0 after MASTERS-1.
- Response:
  - slave_rvalid_i pops the FIFO head.
  - master_rvalid_o[head] = 1 in the same cycle (combinational, no added latency).
  - master_rdata_o is slave_rdata_i broadcast to all masters; only the rvalid is steered.
- Full FIFO: no new request is presented, even if a pop occurs the same cycle. This keeps rvalid->req free of combinational paths. Push and pop in the same cycle with the FIFO not full is legal; count is unchanged.
- Empty FIFO with slave_rvalid_i: no master rvalid, resp_err_o <= 1 (cleared only by reset).
- Single requester: granted every accept cycle; the pointer still advances.

Optional Feature:
- Macro OBI_RR_ARB_BURST_LOCK_EN.
- Defined:
  - A burst counter holds priority on the last-accepted master while its master_req_i stays high in ARB_IDLE, for up to MAX_BURST consecutive accepts.
  - rr_ptr advances only when the burst ends: the master deasserts req, or the count reaches MAX_BURST.
  - The counter resets to 0 when the burst ends.
- Undefined: pure round-robin. The pointer moves after every accept; no burst counter is instantiated.

Decomposition:
- Package obi_arb_pkg:
  - typedef enum arb_state_e {ARB_IDLE, ARB_HOLD}.
  - localparam OBI_ADDR_W=32, OBI_DATA_W=32, OBI_BE_W=4.
- Sub-module obi_arb_id_fifo:
  - Parameterised depth/width sync FIFO with async active-high reset.
  - Ports: push, pop, wdata, rdata, full, empty.

Test Plan:
- Masters 0, 1, 2 all request continuously, slave_gnt_i=1, rvalid one cycle later -> grants in order 0, 1, 2, 0, 1, 2; each rvalid lands on the matching master with its rdata.
- Master 1 requests addr 0x100 while slave_gnt_i=0 for 3 cycles, and master 0 raises req at cycle 2 -> slave_addr_o stays 0x100 (ARB_HOLD) until grant; master 0 is served next.
- MAX_OUTSTANDING=2, slave withholds rvalid, 3 requests pending -> two accepts, then slave_req_o=0; one rvalid pops and the third is accepted the following cycle.
- slave_rvalid_i pulsed with the FIFO empty -> no master_rvalid_o; resp_err_o=1 and stays 1 until rst_i.
- rst_i asserted with 2 outstanding, then released -> all outputs 0, rr_ptr=0; the first arbitration grants master 0 when all request.
- With OBI_RR_ARB_BURST_LOCK_EN, MAX_BURST=4, masters 0 and 2 requesting continuously -> grants 0, 0, 0, 0, 2, 2, 2, 2, 0...
